// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: channel-mux FSM states and a lowest-set-bit
// priority encoder, also used by the round-robin arbiter.
package axis_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    PACKET = 1'b1
  } mux_state_e;

  // Widest select vector the encoder accepts; callers zero-extend narrower vectors.
  localparam int ONEHOT_MAX_W = 64;
  localparam int ONEHOT_IDX_W = $clog2(ONEHOT_MAX_W);

  // Index of the lowest set bit; returns 0 for an all-zero vector.
  function automatic logic [ONEHOT_IDX_W-1:0] onehot_to_index(
    input logic [ONEHOT_MAX_W-1:0] vec
  );
    logic [ONEHOT_IDX_W-1:0] idx;
    idx = '0;
    for (int i = ONEHOT_MAX_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = ONEHOT_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice: main register drives the output, skid register
// absorbs the one beat in flight when the sink stalls.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q;
  logic             accept;
  logic             consume;

  assign accept  = in_valid_i & in_ready_q;
  assign consume = main_valid_q & out_ready_i;

  always_comb begin
    main_data_d  = main_data_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      // Main is necessarily full here and the input is stalled.
      if (out_ready_i) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else begin
      if (consume) main_valid_d = 1'b0;
      if (accept) begin
        if (!main_valid_q || consume) begin
          main_data_d  = in_data_i;
          main_valid_d = 1'b1;
        end else begin
          skid_data_d  = in_data_i;
          skid_valid_d = 1'b1;
        end
      end
    end
  end

  // in_ready_q mirrors ~skid_valid_q once out of reset, so ready never
  // depends combinationally on out_ready_i; it is held low during reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_data_q  <= '0;
      main_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_data_q  <= main_data_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= ~skid_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_data_o  = main_data_q;
  assign out_valid_o = main_valid_q;

endmodule

// File: rtl/axis_channel_mux.sv
// Routes the arbiter-selected slave channel onto one AXI-Stream master,
// locking the selection for a whole packet. Handshake: a beat transfers on
// any edge where valid & ready; valid never waits on ready, ready is registered.
module axis_channel_mux
  import axis_pkg::*;
#(
  parameter  int CHANNEL_NUM = 8,
  parameter  int DATA_WIDTH  = 32,
  localparam int ID_WIDTH    = $clog2(CHANNEL_NUM)
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [CHANNEL_NUM-1:0]            sel_i,
  input  logic [CHANNEL_NUM*DATA_WIDTH-1:0] s_tdata,
  input  logic [CHANNEL_NUM-1:0]            s_tvalid,
  input  logic [CHANNEL_NUM-1:0]            s_tlast,
  output logic [CHANNEL_NUM-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]             m_tdata,
  output logic                              m_tvalid,
  output logic                              m_tlast,
  output logic [ID_WIDTH-1:0]               m_tid,
  input  logic                              m_tready,
  output logic                              busy_o
);

  localparam int PAYLOAD_W = DATA_WIDTH + 1 + ID_WIDTH;

  mux_state_e             state_q;
  logic [ID_WIDTH-1:0]    lock_ch_q;
  logic                   busy_q;

  logic [ID_WIDTH-1:0]    sel_idx;
  logic [ID_WIDTH-1:0]    cur_ch;
  logic                   ch_en;
  logic [DATA_WIDTH-1:0]  cur_data;
  logic                   cur_valid;
  logic                   cur_last;
  logic                   buf_ready;
  logic                   accept;
  logic [PAYLOAD_W-1:0]   in_payload;
  logic [PAYLOAD_W-1:0]   out_payload;
  logic [DATA_WIDTH-1:0]  lane_data [CHANNEL_NUM];

  for (genvar k = 0; k < CHANNEL_NUM; k++) begin : g_lane
    assign lane_data[k] = s_tdata[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Multi-hot selects resolve to the lowest index.
  assign sel_idx = ID_WIDTH'(onehot_to_index(ONEHOT_MAX_W'(sel_i)));

  always_comb begin
    cur_ch = sel_idx;
    ch_en  = |sel_i;
    if (state_q == PACKET) begin
      cur_ch = lock_ch_q;
      ch_en  = 1'b1;
    end
    cur_data  = lane_data[cur_ch];
    cur_valid = ch_en & s_tvalid[cur_ch];
    cur_last  = s_tlast[cur_ch];
    s_tready  = '0;
    if (ch_en) s_tready[cur_ch] = buf_ready;
  end

  assign accept     = cur_valid & buf_ready;
  assign in_payload = {cur_data, cur_last, cur_ch};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      lock_ch_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && !cur_last) begin
            state_q   <= PACKET;
            lock_ch_q <= cur_ch;
            busy_q    <= 1'b1;
          end
        end
        PACKET: begin
          if (accept && cur_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_n_i && state_q == IDLE) begin
      assert ($onehot0(sel_i))
        else $warning("axis_channel_mux: sel_i is multi-hot, lowest index taken");
    end
  end

  axis_skid_buffer #(
    .WIDTH (PAYLOAD_W)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_data_i   (in_payload),
    .in_valid_i  (cur_valid),
    .in_ready_o  (buf_ready),
    .out_data_o  (out_payload),
    .out_valid_o (m_tvalid),
    .out_ready_i (m_tready)
  );

  assign {m_tdata, m_tlast, m_tid} = out_payload;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_axis_channel_mux.sv
// Randomized bench for axis_channel_mux against a queue-based reference model
// of a locked-channel, two-deep registered stream stage.
module tb_axis_channel_mux;

  localparam int CH    = 8;
  localparam int DW    = 32;
  localparam int IW    = 3;
  localparam int BW    = DW + 1 + IW;
  localparam int VEC_W = CH + 2 + BW;

  logic             clk;
  logic             rst_n;
  logic [CH-1:0]    sel;
  logic [CH*DW-1:0] s_tdata;
  logic [CH-1:0]    s_tvalid;
  logic [CH-1:0]    s_tlast;
  logic [CH-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid;
  logic             m_tlast;
  logic [IW-1:0]    m_tid;
  logic             m_tready;
  logic             busy;

  axis_channel_mux #(
    .CHANNEL_NUM (CH),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .sel_i    (sel),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tid    (m_tid),
    .m_tready (m_tready),
    .busy_o   (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model state ----------------
  logic [DW:0]      src_q [CH][$];   // pending {data, last} per channel
  logic [BW-1:0]    exp_q [$];       // beats held by the stage, oldest first
  bit               locked;
  int               lock_ch;
  bit               armed;           // ready is low for the first cycle after reset
  int               p_ch;
  bit               p_acc;
  bit               p_cons;
  logic [VEC_W-1:0] exp_vec;
  logic [VEC_W-1:0] obs_vec;
  int               vectors;
  int               miscompares;

  task automatic model_reset();
    exp_q.delete();
    for (int c = 0; c < CH; c++) src_q[c].delete();
    locked = 1'b0;
    lock_ch = 0;
    armed = 1'b0;
  endtask

  function automatic bit drained();
    bit d;
    d = (exp_q.size() == 0);
    for (int c = 0; c < CH; c++) if (src_q[c].size() != 0) d = 1'b0;
    return d;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_sources(input int pct);
    for (int c = 0; c < CH; c++) begin
      if (src_q[c].size() > 0) begin
        s_tvalid[c] = ($urandom_range(99) < pct);
        s_tdata[c*DW +: DW] = src_q[c][0][DW:1];
        s_tlast[c] = src_q[c][0][0];
      end else begin
        s_tvalid[c] = 1'b0;
        s_tlast[c] = 1'($urandom_range(1));
        s_tdata[c*DW +: DW] = $urandom;
      end
    end
  endtask

  task automatic push_packet(input int ch, input int len);
    for (int i = 0; i < len; i++) src_q[ch].push_back({DW'($urandom), i == len - 1});
  endtask

  // Expected outputs this cycle, sampled on the falling edge.
  task automatic predict();
    bit en, rdy;
    logic [BW-1:0] head;
    @(negedge clk);
    en = 1'b0;
    p_ch = 0;
    if (locked) begin
      en = 1'b1;
      p_ch = lock_ch;
    end else begin
      for (int c = CH - 1; c >= 0; c--) if (sel[c]) begin en = 1'b1; p_ch = c; end
    end
    rdy = en && armed && (exp_q.size() < 2);
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    exp_vec = {rdy ? CH'(1 << p_ch) : CH'(0), exp_q.size() > 0, locked, head};
    obs_vec = {s_tready, m_tvalid, busy, (exp_q.size() > 0) ? {m_tdata, m_tlast, m_tid} : BW'(0)};
    p_acc  = rdy && s_tvalid[p_ch];
    p_cons = (exp_q.size() > 0) && m_tready;
  endtask

  task automatic advance();
    logic last;
    @(posedge clk);
    if (p_cons) void'(exp_q.pop_front());
    if (p_acc) begin
      last = s_tlast[p_ch];
      exp_q.push_back({s_tdata[p_ch*DW +: DW], last, IW'(p_ch)});
      if (src_q[p_ch].size() > 0) void'(src_q[p_ch].pop_front());
      if (!locked && !last) begin
        locked = 1'b1;
        lock_ch = p_ch;
      end else if (locked && last) begin
        locked = 1'b0;
      end
    end
    armed = 1'b1;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    sel = 8'h04;
    s_tvalid = '1;
    s_tlast = '0;
    s_tdata = {CH{DW'($urandom)}};
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (s_tready !== 8'h00) begin miscompares++; $display("FAIL reset.s_tready: got %h, expected 00", s_tready); end
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset.m_tvalid: got %b, expected 0", m_tvalid); end
    vectors++; if (m_tlast !== 1'b0) begin miscompares++; $display("FAIL reset.m_tlast: got %b, expected 0", m_tlast); end
    vectors++; if (m_tdata !== 32'h0) begin miscompares++; $display("FAIL reset.m_tdata: got %h, expected 0", m_tdata); end
    vectors++; if (m_tid !== 3'd0) begin miscompares++; $display("FAIL reset.m_tid: got %0d, expected 0", m_tid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset.busy_o: got %b, expected 0", busy); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    s_tvalid = '0;
  endtask

  task automatic test_single_packet();
    int seen = 0;
    for (int i = 0; i < 4; i++) src_q[2].push_back({DW'(32'hA0 + i), i == 3});
    sel = 8'h04;
    m_tready = 1'b1;
    for (int cyc = 0; cyc < 30 && !drained(); cyc++) begin
      drive_sources(100);
      predict();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL single cyc %0d: got %h, expected %h", cyc, obs_vec, exp_vec); end
      if (m_tvalid && m_tready) seen++;
      advance();
    end
    vectors++; if (!drained()) begin miscompares++; $display("FAIL single.timeout: got %0d beats left, expected 0", exp_q.size()); end
    vectors++; if (seen != 4) begin miscompares++; $display("FAIL single.beat_count: got %0d, expected 4", seen); end
  endtask

  task automatic test_backpressure();
    logic [6:0] pat = 7'b1101001;
    for (int i = 0; i < 4; i++) src_q[2].push_back({DW'(32'hA0 + i), i == 3});
    sel = 8'h04;
    for (int cyc = 0; cyc < 40 && !drained(); cyc++) begin
      m_tready = (cyc < 7) ? pat[cyc] : 1'b1;
      drive_sources(100);
      predict();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL backpressure cyc %0d: got %h, expected %h", cyc, obs_vec, exp_vec); end
      advance();
    end
    vectors++; if (!drained()) begin miscompares++; $display("FAIL backpressure.timeout: got %0d beats left, expected 0", exp_q.size()); end
  endtask

  task automatic test_sel_switch();
    push_packet(2, 4);
    push_packet(4, 3);
    m_tready = 1'b1;
    for (int cyc = 0; cyc < 40 && !drained(); cyc++) begin
      sel = (src_q[2].size() > 2) ? 8'h04 : 8'h10;
      drive_sources(100);
      predict();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL sel_switch cyc %0d: got %h, expected %h", cyc, obs_vec, exp_vec); end
      advance();
    end
    vectors++; if (!drained()) begin miscompares++; $display("FAIL sel_switch.timeout: got %0d beats left, expected 0", exp_q.size()); end
  endtask

  task automatic test_no_select();
    for (int c = 0; c < CH; c++) push_packet(c, (c == 3) ? 2 : 1);
    m_tready = 1'b1;
    sel = 8'h00;
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive_sources(100);
      predict();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL no_select cyc %0d: got %h, expected %h", cyc, obs_vec, exp_vec); end
      advance();
    end
    sel = 8'h28;
    for (int cyc = 0; cyc < 20 && (src_q[3].size() > 0 || exp_q.size() > 0); cyc++) begin
      drive_sources(100);
      predict();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL multi_hot cyc %0d: got %h, expected %h", cyc, obs_vec, exp_vec); end
      advance();
    end
    vectors++; if (src_q[3].size() != 0) begin miscompares++; $display("FAIL multi_hot.timeout: got %0d beats left, expected 0", src_q[3].size()); end
    for (int c = 0; c < CH; c++) src_q[c].delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] order [3] = '{8'h01, 8'h02, 8'h01};
    int k = 0;
    int first = -1;
    int last = -1;
    int seen = 0;
    src_q[0].push_back({DW'($urandom), 1'b1});
    src_q[0].push_back({DW'($urandom), 1'b1});
    src_q[1].push_back({DW'($urandom), 1'b1});
    m_tready = 1'b1;
    for (int cyc = 0; cyc < 20 && !drained(); cyc++) begin
      sel = (k < 3) ? order[k] : 8'h00;
      drive_sources(100);
      predict();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL back_to_back cyc %0d: got %h, expected %h", cyc, obs_vec, exp_vec); end
      if (m_tvalid) begin
        seen++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (p_acc) k++;
      advance();
    end
    vectors++; if (seen != 3) begin miscompares++; $display("FAIL back_to_back.count: got %0d, expected 3", seen); end
    vectors++; if (first != 1 || last != 3) begin miscompares++; $display("FAIL back_to_back.cycles: got %0d..%0d, expected 1..3", first, last); end
  endtask

  task automatic test_reset_mid_packet();
    push_packet(1, 6);
    sel = 8'h02;
    m_tready = 1'b0;
    for (int cyc = 0; cyc < 10 && exp_q.size() < 2; cyc++) begin
      drive_sources(100);
      predict();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL rst_mid.fill cyc %0d: got %h, expected %h", cyc, obs_vec, exp_vec); end
      advance();
    end
    vectors++; if (exp_q.size() != 2) begin miscompares++; $display("FAIL rst_mid.fill_timeout: got %0d, expected 2", exp_q.size()); end
    #3 rst_n = 1'b0;
    #1;
    vectors++; if (m_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_mid.m_tvalid: got %b, expected 0", m_tvalid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid.busy_o: got %b, expected 0", busy); end
    vectors++; if (s_tready !== 8'h00) begin miscompares++; $display("FAIL rst_mid.s_tready: got %h, expected 00", s_tready); end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_packet(6, 4);
    sel = 8'h40;
    for (int cyc = 0; cyc < 60 && !drained(); cyc++) begin
      m_tready = 1'($urandom_range(1));
      drive_sources(100);
      predict();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL rst_mid.recover cyc %0d: got %h, expected %h", cyc, obs_vec, exp_vec); end
      advance();
    end
    vectors++; if (!drained()) begin miscompares++; $display("FAIL rst_mid.timeout: got %0d beats left, expected 0", exp_q.size()); end
  endtask

  task automatic test_random();
    int r;
    for (int p = 0; p < 16; p++) push_packet($urandom_range(CH - 1), $urandom_range(1, 5));
    for (int cyc = 0; cyc < 4000 && !drained(); cyc++) begin
      r = $urandom_range(9);
      if (r == 0) sel = 8'h00;
      else if (r < 7) sel = 8'(1 << $urandom_range(CH - 1));
      else sel = 8'($urandom);
      m_tready = ($urandom_range(3) != 0);
      drive_sources(80);
      predict();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL random cyc %0d: got %h, expected %h", cyc, obs_vec, exp_vec); end
      advance();
    end
    vectors++; if (!drained()) begin miscompares++; $display("FAIL random.timeout: got %0d beats left, expected 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    sel = '0;
    s_tdata = '0;
    s_tvalid = '0;
    s_tlast = '0;
    m_tready = 1'b0;
    model_reset();
    test_reset();
    test_single_packet();
    test_backpressure();
    test_sel_switch();
    test_no_select();
    test_back_to_back();
    test_reset_mid_packet();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
